// File: rtl/adder_pkg.sv
// Shared definitions for the 4-operand summation path: operand count,
// result-width rule and the collector fill-state names.
package adder_pkg;

  localparam int NUM_OPS = 4;

  // One extra bit beyond the exact growth keeps the 35-bit downstream format for 32-bit operands.
  function automatic int sum_width(input int data_w, input int num_ops);
    return data_w + $clog2(num_ops) + 1;
  endfunction

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } fill_state_e;

endpackage

// File: rtl/operand_collector_sum4_if.sv
// Operand stream in, group-sum stream out, plus the emitted-group counter.
interface operand_collector_sum4_if import adder_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) ();

  localparam int SUM_W = sum_width(DATA_W, NUM_OPS);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_sum;
  logic [CNT_W-1:0]  grp_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, grp_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, grp_count
  );

endinterface

// File: rtl/multiple_adder_csa_4x32.sv
// Combinational sum of four 32-bit unsigned operands: two carry-save
// compression stages followed by one carry-propagate add, 35-bit result.
module multiple_adder_csa_4x32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [34:0] sum
);

  logic [34:0] a_x, b_x, c_x, d_x;
  logic [34:0] s1, c1, s2, c2;

  assign a_x = 35'(a);
  assign b_x = 35'(b);
  assign c_x = 35'(c);
  assign d_x = 35'(d);

  // Operands stay below 2^34, so the carry shifts never lose a set bit.
  assign s1  = a_x ^ b_x ^ c_x;
  assign c1  = ((a_x & b_x) | (a_x & c_x) | (b_x & c_x)) << 1;

  assign s2  = s1 ^ c1 ^ d_x;
  assign c2  = ((s1 & c1) | (s1 & d_x) | (c1 & d_x)) << 1;

  assign sum = s2 + c2;

endmodule

// File: rtl/operand_collector_sum4.sv
// Collects a serial operand stream into groups of four and emits each
// group's registered sum over a valid/ready output with a group counter.
module operand_collector_sum4 import adder_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  operand_collector_sum4_if.slave bus
);

  localparam int SUM_W  = sum_width(DATA_W, NUM_OPS);
  localparam int FILL_W = $clog2(NUM_OPS + 1);
  localparam int IDX_W  = $clog2(NUM_OPS);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NUM_OPS);

  logic [FILL_W-1:0] cnt;
  logic [DATA_W-1:0] slot [NUM_OPS];
  logic              out_valid_q;
  logic [SUM_W-1:0]  sum_d;
  logic [SUM_W-1:0]  sum_q;
  logic [CNT_W-1:0]  grp_q;
  logic              not_full;
  logic              accept;
  logic              xfer;

  // Ready comes from the fill count alone, so the producer never sees a path from in_valid.
  assign not_full = (cnt < FILL_FULL);
  assign accept   = bus.in_valid && not_full;
  assign xfer     = (cnt == FILL_FULL) && (!out_valid_q || bus.out_ready);

  generate
    if (DATA_W == 32) begin : g_csa
      multiple_adder_csa_4x32 u_csa (
        .a   (slot[0]),
        .b   (slot[1]),
        .c   (slot[2]),
        .d   (slot[3]),
        .sum (sum_d)
      );
    end else begin : g_beh
      // NOTE: an always_comb output gets a default before any accumulation, so no path can infer a latch.
      always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
          sum_d = sum_d + SUM_W'(slot[i]);
        end
      end
    end
  endgenerate

  // NOTE: sequential state is assigned with <= so every register sees pre-edge values.
  // NOTE: the four slots are reset too, so no operand from before a reset can ever reach out_sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      grp_q       <= '0;
      for (int i = 0; i < NUM_OPS; i++) begin
        slot[i] <= '0;
      end
    end else begin
      if (accept) begin
        slot[cnt[IDX_W-1:0]] <= bus.in_data;
        cnt                  <= cnt + 1'b1;
      end

      if (xfer) begin
        sum_q       <= sum_d;
        out_valid_q <= 1'b1;
        cnt         <= '0;
        grp_q       <= grp_q + 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = not_full;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.grp_count = grp_q;

endmodule

// File: tb/tb_operand_collector_sum4.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, and a randomized soak.
module tb_operand_collector_sum4;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int SUM_W  = 35;

  logic clk;
  logic rst_n;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  operand_collector_sum4_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  operand_collector_sum4 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: pending operands in a queue, one output register, a group counter.
  logic [DATA_W-1:0] mq[$];
  bit                m_valid = 1'b0;
  logic [SUM_W-1:0]  m_sum   = '0;
  logic [CNT_W-1:0]  m_grp   = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_valid = 1'b0;
      m_sum   = '0;
      m_grp   = '0;
    end else begin
      bit full;
      bit do_xfer;
      full    = (mq.size() == 4);
      do_xfer = full && (!m_valid || bus.out_ready);
      if (bus.in_valid && !full) mq.push_back(bus.in_data);
      if (do_xfer) begin
        m_sum = '0;
        foreach (mq[i]) m_sum = m_sum + SUM_W'(mq[i]);
        mq.delete();
        m_valid = 1'b1;
        m_grp   = m_grp + 1'b1;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Every cycle out of reset, compare all outputs against the model; log valid cycles.
  int vcyc[$];
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      check("in_ready",  64'(bus.in_ready),  64'(mq.size() < 4));
      check("out_valid", 64'(bus.out_valid), 64'(m_valid));
      check("out_sum",   64'(bus.out_sum),   64'(m_sum));
      check("grp_count", 64'(bus.grp_count), 64'(m_grp));
      if (bus.out_valid === 1'b1) vcyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!done && n < 50) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) check("send_timeout", 64'(done), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    #3;
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_sum",   64'(bus.out_sum),   64'd0);
    check("rst_grp_count", 64'(bus.grp_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic group with exact one-cycle latency after the 4th accept.
    for (int i = 1; i <= 4; i++) send_word(DATA_W'(i));
    check("basic_not_early", 64'(bus.out_valid), 64'd0);
    tick();
    check("basic_valid", 64'(bus.out_valid), 64'd1);
    check("basic_sum",   64'(bus.out_sum),   64'd10);
    check("basic_grp",   64'(bus.grp_count), 64'd1);
    tick();
    check("basic_pulse", 64'(bus.out_valid), 64'd0);

    // Maximum operands.
    do_reset();
    for (int i = 0; i < 4; i++) send_word(32'hFFFF_FFFF);
    tick();
    check("max_sum",   64'(bus.out_sum),     64'h3_FFFF_FFFC);
    check("max_msb",   64'(bus.out_sum[34]), 64'd0);
    check("max_valid", 64'(bus.out_valid),   64'd1);

    // Backpressure: first result held while the next group fills and stalls.
    do_reset();
    bus.out_ready = 1'b0;
    send_word(32'd10); send_word(32'd20); send_word(32'd30); send_word(32'd40);
    for (int i = 0; i < 4; i++) send_word(32'd1);
    check("bp_in_ready", 64'(bus.in_ready),  64'd0);
    check("bp_hold_sum", 64'(bus.out_sum),   64'd100);
    check("bp_hold_val", 64'(bus.out_valid), 64'd1);
    repeat (3) tick();
    check("bp_still_sum", 64'(bus.out_sum),  64'd100);
    check("bp_still_rdy", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_swap_sum", 64'(bus.out_sum),   64'd4);
    check("bp_swap_val", 64'(bus.out_valid), 64'd1);
    check("bp_swap_grp", 64'(bus.grp_count), 64'd2);
    tick();
    check("bp_held_new", 64'(bus.out_sum), 64'd4);
    bus.out_ready = 1'b1;
    tick();

    // Input gaps: non-valid cycles carry junk and must be ignored.
    do_reset();
    begin
      bit          pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [31:0] dat [7] = '{32'd5, 32'd0, 32'd0, 32'd6, 32'd7, 32'd0, 32'd8};
      for (int i = 0; i < 7; i++) begin
        bus.in_valid = pat[i];
        bus.in_data  = pat[i] ? dat[i] : $urandom();
        tick();
      end
    end
    bus.in_valid = 1'b0;
    tick();
    check("gap_sum",   64'(bus.out_sum),   64'd26);
    check("gap_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b0;

    // Reset mid-group with a pending result: everything clears at once.
    for (int i = 0; i < 3; i++) send_word(32'd100 + 32'(i));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_grp",   64'(bus.grp_count), 64'd0);
    check("mid_rst_rdy",   64'(bus.in_ready),  64'd1);
    check("mid_rst_sum",   64'(bus.out_sum),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send_word(32'd2);
    tick();
    check("post_rst_sum", 64'(bus.out_sum),   64'd8);
    check("post_rst_grp", 64'(bus.grp_count), 64'd1);

    // Throughput: 20 streaming words -> 5 results, 5 cycles apart.
    do_reset();
    vcyc.delete();
    for (int i = 0; i < 20; i++) send_word($urandom());
    repeat (3) tick();
    check("tp_results", 64'(vcyc.size()),    64'd5);
    check("tp_grp",     64'(bus.grp_count),  64'd5);
    for (int i = 1; i < vcyc.size(); i++)
      check("tp_spacing", 64'(vcyc[i] - vcyc[i-1]), 64'd5);

    // Randomized soak against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
